// File: rtl/mips_isa_pkg.sv
// Shared MIPS ISA definitions: opcodes, request-kind encoding, field widths and
// a packing helper used by both the issue encoder and the control decoder.
package mips_isa_pkg;

    localparam int OPCODE_W = 6;
    localparam int REG_W    = 5;
    localparam int SHAMT_W  = 5;
    localparam int FUNCT_W  = 6;
    localparam int IMM_W    = 16;
    localparam int KIND_W   = 2;
    localparam int INSTR_W  = 32;

    localparam logic [OPCODE_W-1:0] OP_RTYPE = 6'h00;
    localparam logic [OPCODE_W-1:0] OP_LW    = 6'h23;
    localparam logic [OPCODE_W-1:0] OP_SW    = 6'h2B;
    localparam logic [OPCODE_W-1:0] OP_BEQ   = 6'h04;

    typedef enum logic [KIND_W-1:0] {
        KIND_R   = 2'b00,
        KIND_LW  = 2'b01,
        KIND_SW  = 2'b10,
        KIND_BEQ = 2'b11
    } instr_kind_e;

    typedef struct packed {
        logic [OPCODE_W-1:0] opcode;
        logic [REG_W-1:0]    rs;
        logic [REG_W-1:0]    rt;
        logic [REG_W-1:0]    rd;
        logic [SHAMT_W-1:0]  shamt;
        logic [FUNCT_W-1:0]  funct;
    } r_fmt_t;

    typedef struct packed {
        logic [OPCODE_W-1:0] opcode;
        logic [REG_W-1:0]    rs;
        logic [REG_W-1:0]    rt;
        logic [IMM_W-1:0]    imm;
    } i_fmt_t;

    // Fields that do not belong to the selected format are simply not packed.
    function automatic logic [INSTR_W-1:0] encode_instr(
        input instr_kind_e         kind,
        input logic [REG_W-1:0]    rs_f,
        input logic [REG_W-1:0]    rt_f,
        input logic [REG_W-1:0]    rd_f,
        input logic [FUNCT_W-1:0]  funct_f,
        input logic [IMM_W-1:0]    imm_f
    );
        r_fmt_t r_word;
        i_fmt_t i_word;
        logic [INSTR_W-1:0] word;

        r_word.opcode = OP_RTYPE;
        r_word.rs     = rs_f;
        r_word.rt     = rt_f;
        r_word.rd     = rd_f;
        r_word.shamt  = '0;
        r_word.funct  = funct_f;

        i_word.opcode = OP_LW;
        i_word.rs     = rs_f;
        i_word.rt     = rt_f;
        i_word.imm    = imm_f;

        word = r_word;
        case (kind)
            KIND_R:   word = r_word;
            KIND_LW:  begin i_word.opcode = OP_LW;  word = i_word; end
            KIND_SW:  begin i_word.opcode = OP_SW;  word = i_word; end
            KIND_BEQ: begin i_word.opcode = OP_BEQ; word = i_word; end
            default:  word = r_word;
        endcase
        return word;
    endfunction

endpackage

// File: rtl/sync_word_fifo.sv
// Single-clock word FIFO with independent occupancy counter; pushes at full and
// pops at empty are ignored so callers may gate loosely.
module sync_word_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic [WIDTH-1:0]         wdata_i,
    output logic [WIDTH-1:0]         rdata_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   fill_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_FILL = (PTR_W+1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   fill_q, fill_d;
    logic             do_push;
    logic             do_pop;

    assign full_o  = (fill_q == FULL_FILL);
    assign empty_o = (fill_q == '0);
    assign fill_o  = fill_q;
    assign rdata_o = mem_q[rd_ptr_q];

    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;

    always_comb begin
        // NOTE: every next-state value gets its hold default first, so no branch can infer a latch.
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        fill_d   = fill_q;
        if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
        case ({do_push, do_pop})
            2'b10:   fill_d = fill_q + (PTR_W+1)'(1);
            2'b01:   fill_d = fill_q - (PTR_W+1)'(1);
            default: fill_d = fill_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: state registers use non-blocking assignments so all flops sample pre-edge values.
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            fill_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            fill_q   <= fill_d;
        end
    end

    // NOTE: storage is not reset; fill_q gates every read, so stale entries are never observed.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata_i;
    end

endmodule

// File: rtl/instr_issue_encoder.sv
// Packs instruction requests into 32-bit MIPS words and queues them for the
// instruction-memory writer over a valid/ready handshake.
module instr_issue_encoder
    import mips_isa_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [KIND_W-1:0]         in_kind,
    input  logic [REG_W-1:0]          in_rs,
    input  logic [REG_W-1:0]          in_rt,
    input  logic [REG_W-1:0]          in_rd,
    input  logic [FUNCT_W-1:0]        in_funct,
    input  logic [IMM_W-1:0]          in_imm,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [INSTR_W-1:0]        out_instr,
    output logic [$clog2(DEPTH):0]    fill,
    output logic [CNT_W-1:0]          issued_count
);

    logic [INSTR_W-1:0] enc_word;
    logic [INSTR_W-1:0] head_word;
    logic [INSTR_W-1:0] last_word_q;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               fifo_full;
    logic               fifo_empty;
    logic               push;
    logic               pop;

    assign enc_word = encode_instr(instr_kind_e'(in_kind), in_rs, in_rt, in_rd, in_funct, in_imm);

    assign in_ready  = ~fifo_full;
    assign out_valid = ~fifo_empty;
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    sync_word_fifo #(
        .WIDTH (INSTR_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (push),
        .pop_i   (pop),
        .wdata_i (enc_word),
        .rdata_o (head_word),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .fill_o  (fill)
    );

    // When drained, the bus keeps showing the last word handed off (0 after reset).
    assign out_instr    = fifo_empty ? last_word_q : head_word;
    assign issued_count = count_q;

    always_comb begin
        count_d = count_q;
        if (pop) count_d = count_q + CNT_W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q     <= '0;
            last_word_q <= '0;
        end else begin
            count_q <= count_d;
            if (pop) last_word_q <= head_word;
        end
    end

endmodule

// File: tb/tb_instr_issue_encoder.sv
// Self-checking bench for instr_issue_encoder: vector table, scoreboard on the
// output handshake, and hand-written full / concurrent / wrap / reset sequences.
module tb_instr_issue_encoder;

    localparam int DEPTH = 4;
    localparam int CNT_W = 4;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  in_kind;
    logic [4:0]  in_rs;
    logic [4:0]  in_rt;
    logic [4:0]  in_rd;
    logic [5:0]  in_funct;
    logic [15:0] in_imm;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [2:0]  fill;
    logic [3:0]  issued_count;

    instr_issue_encoder #(
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_kind      (in_kind),
        .in_rs        (in_rs),
        .in_rt        (in_rt),
        .in_rd        (in_rd),
        .in_funct     (in_funct),
        .in_imm       (in_imm),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_instr    (out_instr),
        .fill         (fill),
        .issued_count (issued_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic [31:0] sb[$];
    logic [3:0]  exp_cnt = 4'd0;

    typedef struct {
        logic [1:0]  kind;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [5:0]  funct;
        logic [15:0] imm;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] model(input logic [1:0] k, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [4:0] rd,
                                          input logic [5:0] fn, input logic [15:0] imm);
        case (k)
            2'b00:   return {6'b000000, rs, rt, rd, 5'b00000, fn};
            2'b01:   return {6'b100011, rs, rt, imm};
            2'b10:   return {6'b101011, rs, rt, imm};
            default: return {6'b000100, rs, rt, imm};
        endcase
    endfunction

    // Scoreboard: sampled on the falling edge, where handshake signals are settled.
    always @(negedge clk) begin
        if (rst_n) begin
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL sb_unexpected_word: got 0x%08h, expected no word", out_instr);
                end else begin
                    check("sb_order", out_instr, sb.pop_front());
                end
                exp_cnt = exp_cnt + 4'd1;
            end
            if (in_valid && in_ready)
                sb.push_back(model(in_kind, in_rs, in_rt, in_rd, in_funct, in_imm));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [1:0] k, input logic [4:0] rs, input logic [4:0] rt,
                         input logic [4:0] rd, input logic [5:0] fn, input logic [15:0] imm);
        in_valid = 1'b1;
        in_kind  = k;
        in_rs    = rs;
        in_rt    = rt;
        in_rd    = rd;
        in_funct = fn;
        in_imm   = imm;
    endtask

    task automatic drive_idx(input int k);
        drive(2'(k % 4), 5'(k + 3), 5'(2 * k + 1), 5'(31 - k), 6'(k * 7 + 1), 16'(k * 4951 + 1));
    endtask

    task automatic idle();
        in_valid = 1'b0;
    endtask

    task automatic drain(input int budget);
        int n = 0;
        out_ready = 1'b1;
        while (out_valid && n < budget) begin
            step();
            n++;
        end
        check("drain_timeout", 32'(out_valid), 32'd0);
    endtask

    // Reset pulse placed mid-cycle, well away from either clock edge.
    task automatic pulse_reset();
        #2;
        rst_n = 1'b0;
        sb.delete();
        exp_cnt = 4'd0;
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{2'b00, 5'd1,  5'd2,  5'd3,  6'h20, 16'h0000, 32'h00221820};
        vecs[1] = '{2'b00, 5'd1,  5'd2,  5'd3,  6'h20, 16'hFFFF, 32'h00221820};
        vecs[2] = '{2'b01, 5'd9,  5'd8,  5'd0,  6'h00, 16'h0004, 32'h8D280004};
        vecs[3] = '{2'b10, 5'd9,  5'd8,  5'd0,  6'h00, 16'h0004, 32'hAD280004};
        vecs[4] = '{2'b11, 5'd1,  5'd2,  5'd0,  6'h00, 16'hFFFF, 32'h1022FFFF};
        vecs[5] = '{2'b11, 5'd1,  5'd2,  5'd31, 6'h3F, 16'hFFFF, 32'h1022FFFF};
        vecs[6] = '{2'b00, 5'd31, 5'd31, 5'd31, 6'h3F, 16'h1234, 32'h03FFF83F};
        vecs[7] = '{2'b01, 5'd0,  5'd31, 5'd7,  6'h15, 16'h8000, 32'h8C1F8000};

        rst_n = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        in_kind = 2'b00;
        in_rs = '0;
        in_rt = '0;
        in_rd = '0;
        in_funct = '0;
        in_imm = '0;

        repeat (2) @(posedge clk);
        #4;
        check("rst_fill", 32'(fill), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_instr", out_instr, 32'd0);
        check("rst_issued", 32'(issued_count), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        rst_n = 1'b1;
        step();

        // Vector table: one request at a time, popped the cycle after it appears.
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            drive(vecs[i].kind, vecs[i].rs, vecs[i].rt, vecs[i].rd, vecs[i].funct, vecs[i].imm);
            step();
            idle();
            check("vec_out_valid", 32'(out_valid), 32'd1);
            check("vec_out_instr", out_instr, vecs[i].exp);
            check("vec_fill", 32'(fill), 32'd1);
            step();
            check("vec_issued", 32'(issued_count), 32'(exp_cnt));
            if (i == 0) check("first_issued", 32'(issued_count), 32'd1);
        end

        // Buffered lw / sw / beq, then released in order.
        out_ready = 1'b0;
        drive(2'b01, 5'd9, 5'd8, 5'd0, 6'h00, 16'h0004); step();
        drive(2'b10, 5'd9, 5'd8, 5'd0, 6'h00, 16'h0004); step();
        drive(2'b11, 5'd1, 5'd2, 5'd0, 6'h00, 16'hFFFF); step();
        idle();
        check("ord_fill", 32'(fill), 32'd3);
        check("ord_head", out_instr, 32'h8D280004);
        step();
        check("ord_stable", out_instr, 32'h8D280004);
        out_ready = 1'b1;
        step();
        check("ord_second", out_instr, 32'hAD280004);
        step();
        check("ord_third", out_instr, 32'h1022FFFF);
        check("ord_fill_1", 32'(fill), 32'd1);
        step();
        check("ord_empty", 32'(out_valid), 32'd0);
        check("ord_hold_last", out_instr, 32'h1022FFFF);

        // Fill to capacity, hold a fifth request, free one slot.
        out_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            drive_idx(k);
            step();
            check("full_in_ready", 32'(in_ready), (k < 3) ? 32'd1 : 32'd0);
        end
        check("full_fill", 32'(fill), 32'd4);
        drive_idx(4);
        step();
        step();
        check("full_held_fill", 32'(fill), 32'd4);
        check("full_held_ready", 32'(in_ready), 32'd0);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check("full_pop_fill", 32'(fill), 32'd3);
        check("full_ready_back", 32'(in_ready), 32'd1);
        step();
        idle();
        check("full_fifth_in", 32'(fill), 32'd4);
        drain(20);

        // Concurrent push/pop at fill=2 for 8 cycles.
        begin
            logic [3:0] base;
            out_ready = 1'b0;
            drive_idx(10); step();
            drive_idx(11); step();
            check("cc_fill_pre", 32'(fill), 32'd2);
            base = exp_cnt;
            out_ready = 1'b1;
            for (int j = 0; j < 8; j++) begin
                drive_idx(12 + j);
                step();
                check("cc_fill", 32'(fill), 32'd2);
            end
            idle();
            check("cc_issued", 32'(issued_count), 32'(base + 4'd8));
            drain(20);
        end

        // Counter wrap: 17 pops from a fresh reset reads 1 with a 4-bit counter.
        idle();
        out_ready = 1'b0;
        pulse_reset();
        rst_n = 1'b1;
        step();
        out_ready = 1'b1;
        for (int j = 0; j < 17; j++) begin
            drive_idx(j);
            step();
        end
        idle();
        step();
        check("wrap_issued", 32'(issued_count), 32'd1);
        check("wrap_fill", 32'(fill), 32'd0);

        // Asynchronous reset with three words buffered.
        out_ready = 1'b0;
        for (int j = 0; j < 3; j++) begin
            drive_idx(20 + j);
            step();
        end
        idle();
        check("mid_fill_pre", 32'(fill), 32'd3);
        pulse_reset();
        check("mid_rst_out_valid", 32'(out_valid), 32'd0);
        check("mid_rst_fill", 32'(fill), 32'd0);
        check("mid_rst_issued", 32'(issued_count), 32'd0);
        check("mid_rst_in_ready", 32'(in_ready), 32'd1);
        check("mid_rst_out_instr", out_instr, 32'd0);
        rst_n = 1'b1;
        out_ready = 1'b1;
        step();
        step();
        check("post_rst_out_valid", 32'(out_valid), 32'd0);
        check("post_rst_fill", 32'(fill), 32'd0);

        check("sb_leftover", 32'(sb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
